// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared types and constants for the DSP48A1 MAC sequencer.
//   seq_state_e : sequencer FSM states
//   OPM_*       : DSP48A1 OPMODE encodings (X=M / Z=P selects) and pre-adder bit
//   seq_tag_t   : per-beat tag {live, first, last} travelling beside the slice pipe
//   tag_opmode  : OPMODE for a tag
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [7:0] OPM_FIRST      = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC        = 8'h09;  // P = P + M
  localparam logic [7:0] OPM_HOLD       = 8'h08;  // P = P
  localparam int         OPM_PREADD_BIT = 4;

  typedef struct packed {
    logic live;
    logic first;
    logic last;
  } seq_tag_t;

  localparam seq_tag_t TAG_BUBBLE = 3'b000;

  // Bubbles always hold P; the pre-adder bit only rides on live beats.
  function automatic logic [7:0] tag_opmode(input seq_tag_t t, input logic preadd);
    logic [7:0] m;
    if (!t.live) begin
      m = OPM_HOLD;
    end else if (t.first) begin
      m = OPM_FIRST;
    end else begin
      m = OPM_ACC;
    end
    if (t.live && preadd) begin
      m[OPM_PREADD_BIT] = 1'b1;
    end else begin
      m[OPM_PREADD_BIT] = m[OPM_PREADD_BIT];
    end
    return m;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_seq_if.sv
// dsp48a1_mac_seq_if: job command, operand stream and result handshakes.
//   master : job issuer (drives cmd_*, op_*, res_ready)
//   slave  : sequencer  (drives cmd_ready, op_ready, res_valid, res_data)
// cmd_preadd and op_d are only consumed when DSP_SEQ_PREADD_EN is defined.
interface dsp48a1_mac_seq_if #(parameter int LEN_W = 8) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_W-1:0]        cmd_len;
  logic                    cmd_preadd;
  logic                    op_valid;
  logic                    op_ready;
  logic signed [17:0]      op_a;
  logic signed [17:0]      op_b;
  logic signed [17:0]      op_d;
  logic                    res_valid;
  logic                    res_ready;
  logic [47:0]             res_data;

  modport master (
    output cmd_valid, cmd_len, cmd_preadd, op_valid, op_a, op_b, op_d, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_preadd, op_valid, op_a, op_b, op_d, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );
endinterface

// File: rtl/dsp_seq_tag_pipe.sv
// dsp_seq_tag_pipe: 3-stage shift register of beat tags, aligned with the
// DSP48A1 operand/M/P register chain.
//   clk, rst_n    : clock, async active-low clear (all stages become bubbles)
//   tag_in        : tag entering stage 1 every cycle (bubble when no beat)
//   stage1..3     : stage taps
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  seq_tag_t tag_in,
  output seq_tag_t stage1,
  output seq_tag_t stage2,
  output seq_tag_t stage3
);

  // Unconditional shift; bubbles fill every idle slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= TAG_BUBBLE;
      stage2 <= TAG_BUBBLE;
      stage3 <= TAG_BUBBLE;
    end else begin
      stage1 <= tag_in;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// dsp48a1_mac_seq: runs dot-product jobs on one DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0).
//   CLK, RST_N         : clock, async active-low reset
//   bus (slave)        : cmd / op / res handshakes
//   dsp_a/b/d          : registered operands to the slice
//   dsp_opmode         : per-beat OPMODE, one cycle after the operands
//   dsp_rst            : sync reset to slice RST* pins, high during RST_N
//   dsp_ce, dsp_carryin: constant 1 / 0
//   dsp_p              : slice P output
// Optional feature macro: DSP_SEQ_PREADD_EN enables cmd_preadd / op_d.
module dsp48a1_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  dsp48a1_mac_seq_if.slave   bus,
  output logic signed [17:0] dsp_a,
  output logic signed [17:0] dsp_b,
  output logic signed [17:0] dsp_d,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_rst,
  output logic               dsp_ce,
  output logic               dsp_carryin,
  input  logic [47:0]        dsp_p
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  seq_state_e       state_r, state_s;
  logic [LEN_W-1:0] len_r, cnt_r, cnt_nxt_s;
  logic             preadd_r, cmd_ready_r, op_ready_r, res_valid_r, cap_r;
  logic [47:0]      res_data_r;
  logic             cmd_fire_s, beat_s, last_beat_s;
  seq_tag_t         tag_in_s, tag1_s, tag2_s, tag3_s;

  assign cmd_fire_s  = bus.cmd_valid && cmd_ready_r;
  assign beat_s      = (state_r == ST_RUN) && bus.op_valid && op_ready_r;
  assign cnt_nxt_s   = cnt_r + LEN_ONE;
  assign last_beat_s = beat_s && (cnt_nxt_s == len_r);

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.op_ready  = op_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign dsp_ce        = 1'b1;
  assign dsp_carryin   = 1'b0;

`ifndef DSP_SEQ_PREADD_EN
  logic unused_s;
  assign unused_s = bus.cmd_preadd ^ (^bus.op_d);
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          if (bus.cmd_len == LEN_ZERO) state_s = ST_DONE;
          else                         state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_beat_s) state_s = ST_DRAIN;
        else             state_s = ST_RUN;
      end
      ST_DRAIN: begin
        // cap_r marks the cycle P holds the final sum.
        if (cap_r) state_s = ST_DONE;
        else       state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (res_valid_r && bus.res_ready) state_s = ST_IDLE;
        else                              state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Tag for the current cycle: a live beat or a bubble.
  always_comb begin
    tag_in_s = TAG_BUBBLE;
    if (beat_s) begin
      tag_in_s.live  = 1'b1;
      tag_in_s.first = (cnt_r == LEN_ZERO);
      tag_in_s.last  = last_beat_s;
    end else begin
      tag_in_s = TAG_BUBBLE;
    end
  end

  dsp_seq_tag_pipe u_tag_pipe (
    .clk    (CLK),
    .rst_n  (RST_N),
    .tag_in (tag_in_s),
    .stage1 (tag1_s),
    .stage2 (tag2_s),
    .stage3 (tag3_s)
  );

  // State, handshake flags, operand registers, OPMODE and result capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      len_r       <= LEN_ZERO;
      cnt_r       <= LEN_ZERO;
      preadd_r    <= 1'b0;
      cmd_ready_r <= 1'b0;
      op_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 48'd0;
      cap_r       <= 1'b0;
      dsp_a       <= 18'sd0;
      dsp_b       <= 18'sd0;
      dsp_d       <= 18'sd0;
      dsp_opmode  <= OPM_HOLD;
      dsp_rst     <= 1'b1;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      dsp_rst     <= 1'b0;
      // Stage-3 tag leaves as its P lands; capture on the following edge.
      cap_r       <= tag3_s.live && tag3_s.last;
      dsp_opmode  <= tag_opmode(tag1_s, preadd_r);

      if (cmd_fire_s) begin
        len_r      <= bus.cmd_len;
        cnt_r      <= LEN_ZERO;
        op_ready_r <= (bus.cmd_len != LEN_ZERO);
`ifdef DSP_SEQ_PREADD_EN
        preadd_r   <= bus.cmd_preadd;
`else
        preadd_r   <= 1'b0;
`endif
      end else if (last_beat_s) begin
        op_ready_r <= 1'b0;
      end

      if (beat_s) begin
        cnt_r <= cnt_nxt_s;
        dsp_a <= bus.op_a;
        dsp_b <= bus.op_b;
`ifdef DSP_SEQ_PREADD_EN
        dsp_d <= bus.op_d;
`else
        dsp_d <= 18'sd0;
`endif
      end

      if ((state_r == ST_IDLE) && cmd_fire_s && (bus.cmd_len == LEN_ZERO)) begin
        res_data_r  <= 48'd0;
        res_valid_r <= 1'b1;
      end else if ((state_r == ST_DRAIN) && cap_r) begin
        res_data_r  <= dsp_p;
        res_valid_r <= 1'b1;
      end else if (res_valid_r && bus.res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// tb_dsp48a1_mac_seq: directed + random jobs against a behavioural DSP48A1
// slice and a plain-arithmetic dot-product reference.
module tb_dsp48a1_mac_seq;

  localparam int LEN_W = 8;
`ifdef DSP_SEQ_PREADD_EN
  localparam bit PRE_BUILD = 1'b1;
`else
  localparam bit PRE_BUILD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  dsp48a1_mac_seq_if #(.LEN_W(LEN_W)) bus ();

  logic signed [17:0] dsp_a, dsp_b, dsp_d;
  logic [7:0]         dsp_opmode;
  logic               dsp_rst, dsp_ce, dsp_carryin;
  logic [47:0]        dsp_p;

  dsp48a1_mac_seq #(.LEN_W(LEN_W)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_d       (dsp_d),
    .dsp_opmode  (dsp_opmode),
    .dsp_rst     (dsp_rst),
    .dsp_ce      (dsp_ce),
    .dsp_carryin (dsp_carryin),
    .dsp_p       (dsp_p)
  );

  // Slice model: A1/B1/D1 -> M (pre-adder applied at the multiplier input
  // using the OPMODE entering its register) -> P via registered OPMODE.
  logic signed [17:0] a1, b1, d1, bsel;
  logic signed [35:0] m_r;
  logic [7:0]         opm_r;
  logic [47:0]        p_r, xmux, zmux;
  assign bsel  = dsp_opmode[4] ? (b1 + d1) : b1;
  assign xmux  = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
  assign zmux  = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
  assign dsp_p = p_r;
  always @(posedge CLK) begin
    if (dsp_rst) begin
      a1 <= 18'sd0; b1 <= 18'sd0; d1 <= 18'sd0;
      m_r <= 36'sd0; opm_r <= 8'h00; p_r <= 48'd0;
    end else if (dsp_ce) begin
      a1 <= dsp_a; b1 <= dsp_b; d1 <= dsp_d;
      m_r <= a1 * bsel;
      opm_r <= dsp_opmode;
      p_r <= zmux + xmux + {47'd0, dsp_carryin};
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int qa[16], qb[16], qd[16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dot product straight from the operand lists, wrapped to 48 bits.
  function automatic logic [47:0] ref_dot(input int len, input bit pre);
    longint acc;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      acc += longint'(qa[i]) * longint'((pre && PRE_BUILD) ? (qb[i] + qd[i]) : qb[i]);
    end
    return acc[47:0];
  endfunction

  task automatic start_cmd(input string tag, input int len, input bit pre);
    int n;
    bus.cmd_valid = 1'b1; bus.cmd_len = LEN_W'(len); bus.cmd_preadd = pre;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    check({tag, "_cmd_wait"}, 64'(n < 20), 64'd1);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input string tag, input int len, input int gap);
    int n;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin bus.op_valid = 1'b0; @(negedge CLK); end
      end
      bus.op_valid = 1'b1;
      bus.op_a = 18'(qa[i]); bus.op_b = 18'(qb[i]); bus.op_d = 18'(qd[i]);
      n = 0;
      while (bus.op_ready !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) check({tag, "_op_wait"}, 64'd0, 64'd1);
      @(negedge CLK);
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input int len, input bit pre, input int gap,
                         input int hold, input int exp_lat, input logic [47:0] expv);
    int n, c0;
    start_cmd(tag, len, pre);
    c0 = cyc;
    if (len == 0) check({tag, "_no_op_ready"}, 64'(bus.op_ready), 64'd0);
    send_beats(tag, len, gap);
    if (len > 0) check({tag, "_op_ready_drop"}, 64'(bus.op_ready), 64'd0);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin
      if (len == 0) check({tag, "_no_op_ready"}, 64'(bus.op_ready), 64'd0);
      @(negedge CLK); n++;
    end
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 64'(cyc - c0), 64'(exp_lat));
    check({tag, "_res_data"}, 64'(bus.res_data), 64'(expv));
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      check({tag, "_hold_data"}, 64'(bus.res_data), 64'(expv));
      check({tag, "_hold_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      check({tag, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
    end
    bus.res_ready = 1'b1;
    @(negedge CLK);
    bus.res_ready = 1'b0;
    check({tag, "_res_drop"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_cmd_ready_back"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    int len, gap, nv;
    bit pre;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_preadd = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_d = '0;
    bus.res_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_op_ready", 64'(bus.op_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_dsp_abd", 64'({dsp_a, dsp_b, dsp_d}), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'h08);
    check("rst_dsp_ctl", 64'({dsp_rst, dsp_ce, dsp_carryin}), 64'b110);
    RST_N = 1'b1;
    check("rel_dsp_rst_before_edge", 64'(dsp_rst), 64'd1);
    @(negedge CLK);
    check("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rel_dsp_rst", 64'(dsp_rst), 64'd0);

    // Directed jobs
    qa[0] = 20; qb[0] = 10; qd[0] = 0;
    run_job("len1_200", 1, 1'b0, 0, 0, 5, 48'h0000000000C8);
    qa[0] = 2; qb[0] = 3; qa[1] = 4; qb[1] = 5; qa[2] = 6; qb[2] = 7;
    qd[0] = 0; qd[1] = 0; qd[2] = 0;
    run_job("len3_full", 3, 1'b0, 0, 0, 7, 48'd68);
    run_job("len3_gap", 3, 1'b0, 2, 0, -1, 48'd68);
    qa[0] = -5; qb[0] = 6;
    run_job("neg_hold", 1, 1'b0, 0, 5, -1, 48'hFFFFFFFFFFE2);
    run_job("len0", 0, 1'b0, 0, 0, -1, 48'd0);

    // Reset in the middle of a 4-beat job
    qa[0] = 7; qb[0] = 7; qa[1] = 8; qb[1] = 8;
    start_cmd("midrst", 4, 1'b0);
    send_beats("midrst", 2, 0);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_dsp_rst", 64'(dsp_rst), 64'd1);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    nv = 0;
    repeat (10) begin @(negedge CLK); if (bus.res_valid) nv++; end
    check("midrst_no_result", 64'(nv), 64'd0);
    qa[0] = 3; qb[0] = 3;
    run_job("after_rst", 1, 1'b0, 0, 0, 5, 48'd9);

    // Pre-adder job
    qa[0] = 5; qb[0] = 6; qd[0] = 25;
    run_job("preadd", 1, 1'b1, 0, 0, 5, PRE_BUILD ? 48'd155 : 48'd30);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      len = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 2));
      pre = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        qa[i] = int'($urandom_range(0, 131071)) - 65536;
        qb[i] = int'($urandom_range(0, 131071)) - 65536;
        qd[i] = int'($urandom_range(0, 131071)) - 65536;
      end
      run_job("random", len, pre, gap, int'($urandom_range(0, 2)), -1, ref_dot(len, pre));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
